// File: rtl/conv_kernel_loader_pkg.sv
// cnn_pkg: layer constants, word-count helpers and loader FSM encoding shared by the CNN blocks.
package cnn_pkg;
    localparam int KERNEL_TAPS = 9;
    localparam int DEF_CHANEL = 4;
    localparam int DEF_FILTER = 8;
    typedef logic [15:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_READ      = 3'd1;
    localparam logic [2:0] ST_DRAIN     = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_FINISH    = 3'd4;
    function automatic int wpf(input int chanel);
        return KERNEL_TAPS * chanel + 1;
    endfunction
    function automatic int total_words(input int chanel, input int filter);
        return filter * wpf(chanel);
    endfunction
    localparam int WPF = wpf(DEF_CHANEL);
    localparam int TOTAL = total_words(DEF_CHANEL, DEF_FILTER);
endpackage

// File: rtl/conv_kernel_loader_if.sv
// conv_kernel_loader_if: weight-ROM read port plus kernel stream towards the convolution layer.
interface conv_kernel_loader_if;
    import cnn_pkg::*;
    logic  rom_en;
    addr_t rom_addr;
    word_t rom_data;
    logic  load_kernel;
    word_t kernel;
    logic  load_kernel_done;
    modport master (output rom_en, rom_addr, load_kernel, kernel, input rom_data, load_kernel_done);
    modport slave  (input rom_en, rom_addr, load_kernel, kernel, output rom_data, load_kernel_done);
endinterface

// File: rtl/conv_kernel_loader.sv
// conv_kernel_loader: streams every filter's weights and bias from the weight ROM into the conv layer.
module conv_kernel_loader
    import cnn_pkg::*;
#(
    parameter int          CHANEL    = DEF_CHANEL,
    parameter int          FILTER    = DEF_FILTER,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    conv_kernel_loader_if.master bus
);
    localparam int TOT = total_words(CHANEL, FILTER);
    localparam int IW = $clog2(TOT + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        state, nxt;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    word_t         kernel_q;
    logic          last_rd, timeout;
    assign busy         = state != ST_IDLE;
    assign bus.rom_en   = state == ST_READ && !hold;
    assign bus.rom_addr = bus.rom_en ? BASE_ADDR + 16'(idx) : '0;
    assign last_rd      = bus.rom_en && idx == IW'(TOT - 1);
    assign timeout      = cnt == CW'(TIMEOUT - 1);
    // ROM data arrives with the strobe; kernel_q keeps the last word between strobes
    assign bus.kernel   = bus.load_kernel ? bus.rom_data : kernel_q;
    always_comb begin
        nxt = state == ST_IDLE      ? (start ? ST_READ : ST_IDLE) :
              state == ST_READ      ? (last_rd ? ST_DRAIN : ST_READ) :
              state == ST_DRAIN     ? ST_WAIT_DONE :
              state == ST_WAIT_DONE ? ((bus.load_kernel_done || timeout) ? ST_FINISH : ST_WAIT_DONE) :
                                      ST_IDLE;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            idx             <= '0;
            cnt             <= '0;
            kernel_q        <= '0;
            bus.load_kernel <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            state           <= nxt;
            idx             <= state == ST_IDLE ? '0 : bus.rom_en ? idx + 1'b1 : idx;
            cnt             <= state == ST_WAIT_DONE ? cnt + 1'b1 : '0;
            bus.load_kernel <= bus.rom_en;
            done            <= state == ST_FINISH;
            if (bus.load_kernel) kernel_q <= bus.rom_data;
            if (state == ST_IDLE && start) error <= 1'b0;
            else if (state == ST_WAIT_DONE && !bus.load_kernel_done && timeout) error <= 1'b1;
        end
    end
endmodule

// File: doc/conv_kernel_loader.md
CONV_KERNEL_LOADER -- requirements
Module: conv_kernel_loader

Interface
REQ-001 SHALL have parameter CHANEL, default 4: input channels per filter.
REQ-002 SHALL have parameter FILTER, default 8: filters in the layer.
REQ-003 SHALL have parameter BASE_ADDR, default 0: weight-ROM address of the first word.
REQ-004 SHALL have parameter TIMEOUT, default 64: cycles allowed for load_kernel_done after the last word.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle request to begin a load; honoured only in IDLE.
REQ-008 SHALL have port hold, input, 1: stall; while high, no new ROM read is issued.
REQ-009 SHALL have port rom_en, output, 1: ROM read enable.
REQ-010 SHALL have port rom_addr, output, 16: ROM read address.
REQ-011 SHALL have port rom_data, input, 32: ROM read data, valid exactly 1 cycle after rom_en.
REQ-012 SHALL have port load_kernel, output, 1: word-valid strobe to the convolution layer.
REQ-013 SHALL have port kernel, output, 32: weight/bias word, qualified by load_kernel.
REQ-014 SHALL have port load_kernel_done, input, 1: completion flag from the convolution layer.
REQ-015 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when the load sequence ends.
REQ-017 SHALL have port error, output, 1: sticky timeout flag; cleared by the next accepted start.

Function
REQ-018 SHALL stream WPF = 9*CHANEL+1 words per filter (9*CHANEL weights, then 1 bias), TOTAL = FILTER*WPF words (296 at defaults), filter 0 first.
REQ-019 SHALL use FSM states IDLE, READ, DRAIN, WAIT_DONE, FINISH.
REQ-020 IDLE->READ on start; word counter cleared; error cleared.
REQ-021 READ: each cycle with hold=0 SHALL assert rom_en and set rom_addr = BASE_ADDR + word index, then increment the index; with hold=1, rom_en=0 and the index SHALL hold.
REQ-022 load_kernel SHALL be rom_en delayed by exactly 1 cycle, and kernel SHALL be rom_data registered on that cycle; kernel SHALL hold its value while load_kernel=0.
REQ-023 The number of load_kernel pulses per sequence SHALL be exactly TOTAL, with no duplicated or skipped address, regardless of hold pattern.
REQ-024 READ->DRAIN on the cycle the read of index TOTAL-1 is issued; DRAIN lasts 1 cycle, then WAIT_DONE.
REQ-025 WAIT_DONE: a cycle counter SHALL start at 0; load_kernel_done=1 -> FINISH; counter reaching TIMEOUT-1 without done -> FINISH with error set.
REQ-026 FINISH SHALL assert done for 1 cycle, then go to IDLE.
REQ-027 start outside IDLE SHALL be ignored; start in the FINISH cycle SHALL be ignored.
REQ-028 load_kernel_done high before WAIT_DONE SHALL be ignored.
REQ-029 hold SHALL have no effect in DRAIN, WAIT_DONE or FINISH.
REQ-030 The word index SHALL be wide enough for TOTAL without wrap; rom_addr SHALL wrap modulo 2^16.

Reset
REQ-031 SHALL, on resetn low, force IDLE, and set rom_en, rom_addr, load_kernel, kernel, busy, done and error to 0, with all counters at 0.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence; no load_kernel SHALL appear after resetn deasserts until a new start.

Structure
REQ-033 WPF, TOTAL and the FSM state encoding SHALL be in shared package cnn_pkg, alongside layer constants.
REQ-034 SHALL be a single module with no sub-modules; the ROM is external.

Verification
REQ-035 Defaults, BASE_ADDR=0, ROM[i]=i, hold=0, done returned 1 cycle after the last word -> 296 load_kernel pulses, kernel values 0..295 in order, first pulse 2 cycles after start, done 1 cycle after FINISH entry, error=0.
REQ-036 Random hold pattern (about 30%) -> kernel stream identical to REQ-035 and exactly 296 pulses.
REQ-037 load_kernel_done never returned -> done pulse TIMEOUT+1 cycles after entering WAIT_DONE, error=1 until next start.
REQ-038 resetn pulsed low at word 100 -> all outputs 0 immediately; no further load_kernel; a new start reproduces the REQ-035 stream from word 0.
REQ-039 start repeated during READ, plus early load_kernel_done -> both ignored; stream and done timing unchanged.
REQ-040 CHANEL=1, FILTER=2, BASE_ADDR=16'hFFF0 -> 20 words, rom_addr wraps from FFFF to 0000.
